// File: rtl/dds_word_capture.sv
// dds_word_capture
// Receive-side endpoint of the DDS parallel-load bus. It rebuilds the
// AD9851-style 5-byte load (W0 = phase/control, W1..W4 = tuning word, MSB
// first) and flags malformed loads.
//
// Ports
//   clk_sys     in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   dds_reset   in   DDS master reset from the controller
//   dds_w_clk   in   word-load strobe, rising edge loads one byte
//   dds_fq_ud   in   frequency-update strobe, rising edge commits the word
//   dds_data    in   parallel data byte
//   freq_word   out  last committed tuning word
//   phase_word  out  last committed W0[7:3]
//   ctrl_bits   out  last committed W0[2:0]
//   word_valid  out  one-cycle pulse on a complete commit
//   short_load  out  one-cycle pulse on fq_ud with fewer than 5 bytes
//   over_load   out  sticky, set by a 6th w_clk edge before fq_ud
//   byte_ptr    out  bytes currently loaded, 0..5
//   load_cnt    out  committed word count, saturating
module dds_word_capture #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        dds_reset,
  input  logic        dds_w_clk,
  input  logic        dds_fq_ud,
  input  logic [7:0]  dds_data,
  output logic [31:0] freq_word,
  output logic [4:0]  phase_word,
  output logic [2:0]  ctrl_bits,
  output logic        word_valid,
  output logic        short_load,
  output logic        over_load,
  output logic [2:0]  byte_ptr,
  output logic [15:0] load_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOADING, S_FULL, S_OVER} state_e;

  localparam int BW = 11;

  // Data travels with the strobes so a byte and its w_clk edge stay aligned
  // through any synchronizer depth.
  logic [BW-1:0] bus_in, bus_s;
  assign bus_in = {dds_reset, dds_w_clk, dds_fq_ud, dds_data};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign bus_s = bus_in;
  end else begin : g_sync
    logic [BW-1:0] sync_q [SYNC_STAGES];
    logic [BW-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = bus_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk_sys) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        if (rst) sync_q[i] <= '0;
        else     sync_q[i] <= sync_d[i];
      end
    end

    assign bus_s = sync_q[SYNC_STAGES-1];
  end

  logic       reset_s, w_s, fq_s;
  logic [7:0] data_s;
  assign {reset_s, w_s, fq_s, data_s} = bus_s;

  // Strobe history: {reset, w_clk, fq_ud}
  logic [2:0] prev_q, prev_d;
  assign prev_d = {reset_s, w_s, fq_s};

  logic reset_rise, w_rise, fq_rise;
  assign reset_rise = reset_s & ~prev_q[2];
  assign w_rise     = w_s     & ~prev_q[1];
  assign fq_rise    = fq_s    & ~prev_q[0];

  state_e          state_q, state_d;
  logic [2:0]      byte_ptr_q, byte_ptr_d;
  logic [0:4][7:0] shadow_q, shadow_d;      // element 0 is W0
  logic [31:0]     freq_q, freq_d;
  logic [4:0]      phase_q, phase_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic            word_valid_q, word_valid_d;
  logic            short_load_q, short_load_d;
  logic            over_load_q, over_load_d;
  logic [15:0]     load_cnt_q, load_cnt_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    state_d      = state_q;
    byte_ptr_d   = byte_ptr_q;
    shadow_d     = shadow_q;
    freq_d       = freq_q;
    phase_d      = phase_q;
    ctrl_d       = ctrl_q;
    word_valid_d = 1'b0;
    short_load_d = 1'b0;
    over_load_d  = over_load_q;
    load_cnt_d   = load_cnt_q;

    if (reset_rise) begin
      state_d     = S_IDLE;
      byte_ptr_d  = '0;
      shadow_d    = '0;
      freq_d      = '0;
      phase_d     = '0;
      ctrl_d      = '0;
      over_load_d = 1'b0;
    end else if (!reset_s) begin
      // fq_ud wins over a coincident w_clk; that byte is dropped outright.
      if (fq_rise) begin
        if (state_q == S_FULL || state_q == S_OVER) begin
          freq_d       = {shadow_q[1], shadow_q[2], shadow_q[3], shadow_q[4]};
          phase_d      = shadow_q[0][7:3];
          ctrl_d       = shadow_q[0][2:0];
          word_valid_d = 1'b1;
          if (load_cnt_q != 16'hFFFF) load_cnt_d = load_cnt_q + 16'd1;
        end else begin
          short_load_d = 1'b1;
          shadow_d     = '0;
        end
        state_d    = S_IDLE;
        byte_ptr_d = '0;
      end else if (w_rise) begin
        case (state_q)
          S_IDLE, S_LOADING: begin
            shadow_d[byte_ptr_q] = data_s;
            byte_ptr_d           = byte_ptr_q + 3'd1;
            state_d              = (byte_ptr_q == 3'd4) ? S_FULL : S_LOADING;
          end
          S_FULL: begin
            state_d     = S_OVER;
            over_load_d = 1'b1;
          end
          default: ;  // S_OVER: extra bytes are ignored
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking so every flop updates from pre-edge values.
    if (rst) begin
      // NOTE: the shadow bytes are reset too; a commit must never expose
      // stale contents from before reset.
      prev_q       <= '0;
      state_q      <= S_IDLE;
      byte_ptr_q   <= '0;
      shadow_q     <= '0;
      freq_q       <= '0;
      phase_q      <= '0;
      ctrl_q       <= '0;
      word_valid_q <= 1'b0;
      short_load_q <= 1'b0;
      over_load_q  <= 1'b0;
      load_cnt_q   <= '0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      byte_ptr_q   <= byte_ptr_d;
      shadow_q     <= shadow_d;
      freq_q       <= freq_d;
      phase_q      <= phase_d;
      ctrl_q       <= ctrl_d;
      word_valid_q <= word_valid_d;
      short_load_q <= short_load_d;
      over_load_q  <= over_load_d;
      load_cnt_q   <= load_cnt_d;
    end
  end

  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign ctrl_bits  = ctrl_q;
  assign word_valid = word_valid_q;
  assign short_load = short_load_q;
  assign over_load  = over_load_q;
  assign byte_ptr   = byte_ptr_q;
  assign load_cnt   = load_cnt_q;

endmodule
